// File: rtl/fee_csp_pkg.sv
// CSP-to-ALTRO channel maps and shared constants for the FEE readout blocks.
// Pure constants; no timing or backpressure of its own.
package fee_csp_pkg;

    typedef logic [6:0] altro_addr_t;

    // lg_readout_sched state encoding
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_CLR     = 3'd1;
    localparam logic [2:0] ST_WAIT_HG = 3'd2;
    localparam logic [2:0] ST_SCAN    = 3'd3;
    localparam logic [2:0] ST_REQ     = 3'd4;
    localparam logic [2:0] ST_DONE    = 3'd5;

    // err_status bit positions
    localparam int ERR_TIMEOUT  = 0;
    localparam int ERR_TRUNC    = 1;
    localparam int ERR_EVT_BUSY = 2;

    localparam altro_addr_t LG_ADDR [0:31] = '{
        7'h2b, 7'h2f, 7'h24, 7'h20, 7'h30, 7'h34, 7'h3f, 7'h3b,
        7'h0b, 7'h0f, 7'h04, 7'h00, 7'h40, 7'h44, 7'h4f, 7'h4b,
        7'h29, 7'h2d, 7'h26, 7'h22, 7'h32, 7'h36, 7'h3d, 7'h39,
        7'h09, 7'h0d, 7'h06, 7'h02, 7'h42, 7'h46, 7'h4d, 7'h49
    };

    // The HG channel of each CSP is the ALTRO neighbour of its LG channel.
    localparam altro_addr_t HG_ADDR [0:31] = '{
        7'h2a, 7'h2e, 7'h25, 7'h21, 7'h31, 7'h35, 7'h3e, 7'h3a,
        7'h0a, 7'h0e, 7'h05, 7'h01, 7'h41, 7'h45, 7'h4e, 7'h4a,
        7'h28, 7'h2c, 7'h27, 7'h23, 7'h33, 7'h37, 7'h3c, 7'h38,
        7'h08, 7'h0c, 7'h07, 7'h03, 7'h43, 7'h47, 7'h4c, 7'h48
    };

endpackage

// File: rtl/lsb_prio_enc32.sv
// Lowest-set-bit priority encoder over 32 bits; purely combinational.
// No handshake: o_vld is low and o_idx is 0 when no bit is set.
module lsb_prio_enc32 (
    input  logic [31:0] i_vec,
    output logic [4:0]  o_idx,
    output logic        o_vld
);

    always_comb begin
        o_idx = 5'd0;
        o_vld = 1'b0;
        // Walk downwards so the lowest set bit is the last one written.
        for (int i = 31; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 5'(i);
                o_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lg_readout_sched.sv
// Per-event LG readout sequencer: clears LG flags, then requests one ALTRO read per flagged-0 CSP.
// hg_done -> first rd_req in 2 cycles; rd_req held until rd_ack or TIMEOUT_CYC cycles elapse.
module lg_readout_sched
    import fee_csp_pkg::*;
#(
    parameter int TIMEOUT_CYC = 1024,
    parameter int MAX_LG      = 32
) (
    input  logic        i_rdoclk,
    input  logic        i_reset,
    input  logic        i_evt_start,
    input  logic        i_hg_done,
    input  logic [31:0] i_lg_flag,
    output logic        o_flag_clear,
    output logic        o_rd_req,
    output logic [6:0]  o_rd_addr,
    input  logic        i_rd_ack,
    output logic        o_lg_done,
    output logic [5:0]  o_lg_count,
    output logic        o_busy,
    output logic [2:0]  o_err_status
);

    localparam int          TO_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [5:0]  MAX_LG_C  = 6'(MAX_LG);
    localparam logic [5:0]  CNT_SAT   = 6'd32;

    logic [2:0]      r_state,     w_state_nxt;
    logic [31:0]     r_pend,      w_pend_nxt;
    logic [TO_W-1:0] r_to_cnt,    w_to_cnt_nxt;
    logic [6:0]      r_rd_addr,   w_rd_addr_nxt;
    logic [5:0]      r_lg_count,  w_lg_count_nxt;
    logic [2:0]      r_err,       w_err_nxt;
    logic [4:0]      w_enc_idx;
    logic            w_enc_vld;

    lsb_prio_enc32 u_enc (
        .i_vec (r_pend),
        .o_idx (w_enc_idx),
        .o_vld (w_enc_vld)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_pend_nxt     = r_pend;
        w_to_cnt_nxt   = r_to_cnt;
        w_rd_addr_nxt  = r_rd_addr;
        w_lg_count_nxt = r_lg_count;
        w_err_nxt      = r_err;

        case (r_state)
            ST_IDLE: begin
                if (i_evt_start) begin
                    w_state_nxt = ST_CLR;
                end
            end
            ST_CLR: begin
                w_lg_count_nxt = 6'd0;
                w_err_nxt      = 3'd0;
                w_state_nxt    = ST_WAIT_HG;
            end
            ST_WAIT_HG: begin
                if (i_hg_done) begin
                    w_pend_nxt  = ~i_lg_flag;
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!w_enc_vld) begin
                    w_state_nxt = ST_DONE;
                end else if (r_lg_count >= MAX_LG_C) begin
                    // Remaining CSPs are dropped for this event.
                    w_err_nxt[ERR_TRUNC] = 1'b1;
                    w_state_nxt          = ST_DONE;
                end else begin
                    w_rd_addr_nxt         = LG_ADDR[w_enc_idx];
                    w_pend_nxt[w_enc_idx] = 1'b0;
                    w_to_cnt_nxt          = '0;
                    w_state_nxt           = ST_REQ;
                end
            end
            ST_REQ: begin
                // An ack on the terminal-count cycle still wins over the timeout.
                if (i_rd_ack) begin
                    if (r_lg_count != CNT_SAT) begin
                        w_lg_count_nxt = r_lg_count + 6'd1;
                    end
                    w_to_cnt_nxt = '0;
                    w_state_nxt  = ST_SCAN;
                end else if (r_to_cnt == TO_LAST) begin
                    w_err_nxt[ERR_TIMEOUT] = 1'b1;
                    w_to_cnt_nxt           = '0;
                    w_state_nxt            = ST_SCAN;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (i_evt_start && (r_state != ST_IDLE)) begin
            w_err_nxt[ERR_EVT_BUSY] = 1'b1;
        end
    end

    always_ff @(posedge i_rdoclk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_pend     <= 32'd0;
            r_to_cnt   <= '0;
            r_rd_addr  <= 7'd0;
            r_lg_count <= 6'd0;
            r_err      <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_pend     <= w_pend_nxt;
            r_to_cnt   <= w_to_cnt_nxt;
            r_rd_addr  <= w_rd_addr_nxt;
            r_lg_count <= w_lg_count_nxt;
            r_err      <= w_err_nxt;
        end
    end

    assign o_flag_clear = (r_state == ST_CLR);
    assign o_rd_req     = (r_state == ST_REQ);
    assign o_lg_done    = (r_state == ST_DONE);
    assign o_busy       = (r_state != ST_IDLE);
    assign o_rd_addr    = r_rd_addr;
    assign o_lg_count   = r_lg_count;
    assign o_err_status = r_err;

endmodule
